// File: rtl/core_pkg.sv
// core_pkg: shared constants, decode bundle type and ID/EX FSM encoding
package core_pkg;
  localparam int XLEN = 32;
  localparam int CTRL_W = 8;
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC = 4;
  localparam int CTRL_BRANCH = 5;
  localparam int CTRL_JUMP = 6;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] pc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [3:0] alu_op;
    logic [CTRL_W-1:0] ctrl;
  } bundle_t;
endpackage

// File: rtl/id_ex_bubble_stage_if.sv
// id_ex_bubble_stage_if: decode-side inputs, hazard/forward controls and EX-side outputs
interface id_ex_bubble_stage_if #(parameter int CNT_W = 16);
  import core_pkg::*;
  logic id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [3:0] id_alu_op;
  logic [CTRL_W-1:0] id_ctrl;
  logic enable_bubble;
  logic enable_rs1_forward_from_wb;
  logic enable_rs2_forward_from_wb;
  logic [XLEN-1:0] wb_data;
  logic flush;
  logic stall_if_id;
  logic ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] ex_rd;
  logic [3:0] ex_alu_op;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_ctrl,
    output enable_bubble, enable_rs1_forward_from_wb, enable_rs2_forward_from_wb, wb_data, flush,
    input stall_if_id, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
    input ex_alu_op, ex_ctrl, stall_count
  );
  modport slave (
    input id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_ctrl,
    input enable_bubble, enable_rs1_forward_from_wb, enable_rs2_forward_from_wb, wb_data, flush,
    output stall_if_id, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
    output ex_alu_op, ex_ctrl, stall_count
  );
endinterface

// File: rtl/id_ex_bubble_stage_operand_fwd_mux.sv
// operand_fwd_mux: picks WB result or register-file data, x0 always reads zero
module operand_fwd_mux
  import core_pkg::*;
(
  input  logic [4:0]      i_rs,
  input  logic            i_fwd,
  input  logic [XLEN-1:0] i_rf_data,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_op
);
  assign o_op = (i_rs == 5'd0) ? '0 : i_fwd ? i_wb_data : i_rf_data;
endmodule

// File: rtl/id_ex_bubble_stage.sv
// id_ex_bubble_stage: ID/EX register with load-use bubble, replay and WB operand forwarding
module id_ex_bubble_stage
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  id_ex_bubble_stage_if.slave bus
);
  state_t r_state, w_next;
  bundle_t r_ex, r_hold, w_id, w_src, w_load;
  logic [CNT_W-1:0] r_stall_count;
  logic [XLEN-1:0] w_op1, w_op2;
  logic w_bubble, w_nop;
  assign w_id = '{valid: bus.id_valid, pc: bus.id_pc, rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
                  rs1_data: bus.id_rs1_data, rs2_data: bus.id_rs2_data, imm: bus.id_imm,
                  alu_op: bus.id_alu_op, ctrl: bus.id_ctrl};
  assign w_src = (r_state == BUBBLE) ? r_hold : w_id;
  operand_fwd_mux u_fwd1 (
    .i_rs(w_src.rs1), .i_fwd(bus.enable_rs1_forward_from_wb),
    .i_rf_data(w_src.rs1_data), .i_wb_data(bus.wb_data), .o_op(w_op1)
  );
  operand_fwd_mux u_fwd2 (
    .i_rs(w_src.rs2), .i_fwd(bus.enable_rs2_forward_from_wb),
    .i_rf_data(w_src.rs2_data), .i_wb_data(bus.wb_data), .o_op(w_op2)
  );
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? RUN : w_next;
  // a bubble always lasts exactly one cycle, so BUBBLE unconditionally returns to RUN
  always_comb
    w_next = (r_state == RUN && w_bubble) ? BUBBLE : RUN;
  // bubble/stall decision and the bundle presented to EX; flush overrides the bubble request
  always_comb begin
    w_bubble = (r_state == RUN) && !bus.flush && bus.id_valid && bus.enable_bubble;
    w_nop = bus.flush || w_bubble;
    w_load = w_src;
    w_load.rs1_data = w_op1;
    w_load.rs2_data = w_op2;
  end
  assign bus.stall_if_id = w_bubble && !reset;
  // EX register, one-shot hold of the stalled bundle, saturating bubble counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex <= '0;
      r_hold <= '0;
      r_stall_count <= '0;
    end else begin
      r_ex <= w_nop ? '0 : w_load;
      r_hold <= w_bubble ? w_id : '0;
      r_stall_count <= r_stall_count + CNT_W'(w_bubble && !(&r_stall_count));
    end
  end
  assign bus.ex_valid = r_ex.valid;
  assign bus.ex_pc = r_ex.pc;
  assign bus.ex_rs1 = r_ex.rs1;
  assign bus.ex_rs2 = r_ex.rs2;
  assign bus.ex_rd = r_ex.rd;
  assign bus.ex_rs1_data = r_ex.rs1_data;
  assign bus.ex_rs2_data = r_ex.rs2_data;
  assign bus.ex_imm = r_ex.imm;
  assign bus.ex_alu_op = r_ex.alu_op;
  assign bus.ex_ctrl = r_ex.ctrl;
  assign bus.stall_count = r_stall_count;
endmodule

// File: tb/tb_id_ex_bubble_stage.sv
// tb_id_ex_bubble_stage: directed checks of pass-through, bubble/replay, flush, x0 guard, reset and saturation
module tb_id_ex_bubble_stage;
  logic clk = 0;
  logic reset;
  int total = 0;
  int bad = 0;
  id_ex_bubble_stage_if bus ();
  id_ex_bubble_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2, input logic [7:0] ctrl,
                       input logic bub, input logic f1, input logic f2, input logic [31:0] wb, input logic fl);
    bus.id_valid = v;
    bus.id_pc = pc;
    bus.id_rs1 = rs1;
    bus.id_rs2 = rs2;
    bus.id_rd = rd;
    bus.id_rs1_data = d1;
    bus.id_rs2_data = d2;
    bus.id_imm = 32'h0000_0004;
    bus.id_alu_op = 4'd3;
    bus.id_ctrl = ctrl;
    bus.enable_bubble = bub;
    bus.enable_rs1_forward_from_wb = f1;
    bus.enable_rs2_forward_from_wb = f2;
    bus.wb_data = wb;
    bus.flush = fl;
    #1;
  endtask
  initial begin
    reset = 1;
    drive(1, 32'h50, 1, 2, 3, 32'h1, 32'h2, 8'h01, 1, 0, 0, 0, 0);
    chk("stall_in_reset", bus.stall_if_id, 0);
    tick();
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_pc", bus.ex_pc, 0);
    chk("rst_ctrl", bus.ex_ctrl, 0);
    chk("rst_cnt", bus.stall_count, 0);
    reset = 0;
    drive(1, 32'h100, 1, 2, 5, 32'h11, 32'h22, 8'h01, 0, 0, 0, 0, 0);
    chk("plain_stall", bus.stall_if_id, 0);
    tick();
    chk("plain_valid", bus.ex_valid, 1);
    chk("plain_pc", bus.ex_pc, 32'h100);
    chk("plain_rs1d", bus.ex_rs1_data, 32'h11);
    chk("plain_rs2d", bus.ex_rs2_data, 32'h22);
    chk("plain_rd", bus.ex_rd, 5);
    chk("plain_ctrl", bus.ex_ctrl, 8'h01);
    drive(1, 32'h104, 2, 3, 6, 32'h77, 32'h33, 8'h03, 1, 0, 0, 0, 0);
    chk("lu_stall", bus.stall_if_id, 1);
    tick();
    chk("lu_nop_valid", bus.ex_valid, 0);
    chk("lu_nop_ctrl", bus.ex_ctrl, 0);
    chk("lu_nop_pc", bus.ex_pc, 0);
    chk("lu_cnt", bus.stall_count, 1);
    drive(1, 32'h108, 4, 5, 7, 32'h44, 32'h55, 8'h01, 1, 1, 0, 32'hDEAD, 0);
    chk("bub_no_stall", bus.stall_if_id, 0);
    tick();
    chk("replay_pc", bus.ex_pc, 32'h104);
    chk("replay_rs1d", bus.ex_rs1_data, 32'hDEAD);
    chk("replay_rs2d", bus.ex_rs2_data, 32'h33);
    chk("replay_rd", bus.ex_rd, 6);
    chk("replay_valid", bus.ex_valid, 1);
    chk("replay_cnt", bus.stall_count, 1);
    drive(1, 32'h108, 4, 5, 7, 32'h44, 32'h55, 8'h01, 0, 0, 0, 0, 0);
    tick();
    chk("after_pc", bus.ex_pc, 32'h108);
    drive(1, 32'h300, 1, 1, 1, 32'h1, 32'h1, 8'h01, 1, 0, 0, 0, 1);
    chk("flbub_stall", bus.stall_if_id, 0);
    tick();
    chk("flbub_valid", bus.ex_valid, 0);
    chk("flbub_cnt", bus.stall_count, 1);
    drive(1, 32'h304, 1, 1, 1, 32'h1, 32'h1, 8'h01, 0, 0, 0, 0, 0);
    tick();
    chk("flbub_run_pc", bus.ex_pc, 32'h304);
    drive(1, 32'h200, 1, 1, 1, 32'h1, 32'h1, 8'h01, 1, 0, 0, 0, 0);
    tick();
    drive(1, 32'h204, 1, 1, 1, 32'h1, 32'h1, 8'h01, 0, 0, 0, 0, 1);
    tick();
    chk("flinb_valid", bus.ex_valid, 0);
    chk("flinb_pc", bus.ex_pc, 0);
    chk("flinb_cnt", bus.stall_count, 2);
    drive(1, 32'h208, 1, 1, 1, 32'h1, 32'h1, 8'h01, 0, 0, 0, 0, 0);
    tick();
    chk("flinb_next_pc", bus.ex_pc, 32'h208);
    chk("flinb_next_valid", bus.ex_valid, 1);
    drive(1, 32'h210, 1, 0, 1, 32'h1, 32'h99, 8'h01, 0, 0, 1, 32'h55, 0);
    tick();
    chk("x0_guard", bus.ex_rs2_data, 0);
    drive(1, 32'h214, 1, 3, 1, 32'h1, 32'h99, 8'h01, 0, 0, 1, 32'h55, 0);
    tick();
    chk("fwd_rs2", bus.ex_rs2_data, 32'h55);
    drive(1, 32'h400, 1, 1, 1, 32'h1, 32'h1, 8'h01, 1, 0, 0, 0, 0);
    tick();
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rstbub_stall", bus.stall_if_id, 0);
    tick();
    chk("rstbub_valid", bus.ex_valid, 0);
    chk("rstbub_pc", bus.ex_pc, 0);
    chk("rstbub_cnt", bus.stall_count, 0);
    reset = 0;
    tick();
    chk("rstbub_drop_valid", bus.ex_valid, 0);
    chk("rstbub_drop_pc", bus.ex_pc, 0);
    force dut.r_stall_count = 16'hFFFF;
    #1;
    release dut.r_stall_count;
    chk("sat_preload", bus.stall_count, 32'hFFFF);
    drive(1, 32'h500, 1, 1, 1, 32'h1, 32'h1, 8'h01, 1, 0, 0, 0, 0);
    chk("sat_stall", bus.stall_if_id, 1);
    tick();
    chk("sat_cnt", bus.stall_count, 32'hFFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("sat_replay_pc", bus.ex_pc, 32'h500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_bubble_stage.md
Name: id_ex_bubble_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32 core. Sits directly downstream of the load-use hazard unit and consumes its enable_bubble and WB-forward enables.
- Inserts a one-cycle NOP bubble on load-use hazards and stalls PC/IF-ID for that cycle. It replays the held decode bundle afterwards.
- Substitutes the WB-stage result for stale register-file operands when a WB forward is flagged.

Parameters:
XLEN, 32, datapath width
CTRL_W, 8, width of the packed decode control bundle (reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, spare)
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  decode bundle valid
id_pc  in  XLEN  decode PC
id_rs1, id_rs2, id_rd  in  5 each  decode register indices
id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
id_imm  in  XLEN  immediate
id_alu_op  in  4  ALU opcode
id_ctrl  in  CTRL_W  control bundle
enable_bubble  in  1  load-use bubble request from the hazard unit
enable_rs1_forward_from_wb, enable_rs2_forward_from_wb  in  1 each  WB forward flags
wb_data  in  XLEN  result currently in WB
flush  in  1  branch/jump redirect from EX
stall_if_id  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX bundle valid
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each
ex_rs1, ex_rs2, ex_rd  out  5 each
ex_alu_op  out  4
ex_ctrl  out  CTRL_W
stall_count  out  CNT_W  number of bubbles inserted, saturating

Behaviour:
- All state changes on posedge clk.
- Reset, synchronous: every ex_* output = 0, ex_valid = 0, stall_count = 0, hold register cleared, FSM = RUN. stall_if_id is combinational and equals 0 under reset.
- NOP is defined as ex_valid = 0 and ex_ctrl = 0; all other ex_* fields = 0.
- Operand select:
  - op1 = enable_rs1_forward_from_wb ? wb_data : rs1_data.
  - op2 = enable_rs2_forward_from_wb ? wb_data : rs2_data.
  - The select is applied in the cycle the bundle is loaded into EX, whether the bundle comes from decode or from the hold register.
  - A forward flag is ignored when the corresponding rs index is 0; op = 0 in that case.
- FSM states: RUN, BUBBLE.
- RUN:
  - flush=1: load NOP; stay in RUN.
  - Else id_valid & enable_bubble: load NOP into EX, capture the whole decode bundle into the hold register, and assert stall_if_id=1 in this same cycle (combinational). Next state is BUBBLE. stall_count increments and saturates at all-ones.
  - Else: load the decode bundle with the operand select applied. ex_valid = id_valid.
- BUBBLE:
  - stall_if_id=0.
  - flush=1: load NOP, discard hold, go to RUN.
  - Else: load the hold bundle with the operand select applied, then go to RUN. Forward flags and wb_data are sampled this cycle, when the load result is in WB.
  - enable_bubble is ignored in BUBBLE; no back-to-back bubble.
- Latency: 1 cycle decode-to-EX with no hazard; 2 cycles for a bubbled instruction.
- Simultaneous events:
  - flush beats enable_bubble; no stall is asserted.
  - Reset beats everything.
  - Reset asserted while in BUBBLE drops the held instruction.
- id_valid=0 with enable_bubble=1 produces no bubble and no stall.

Decomposition:
- Shared package core_pkg:
  - XLEN and CTRL_W constants.
  - Control-bit index constants (CTRL_REG_WRITE … CTRL_JUMP).
  - ALU opcode localparams.
  - FSM state encoding, RUN=1'b0 and BUBBLE=1'b1.
- One sub-module: operand_fwd_mux, a 2:1 select with the x0 guard, instantiated once per operand.

Test Plan:
- Plain flow: id_valid=1, pc=0x100, rd=5, rs1_data=0x11, ctrl=0x01, no hazard. Next cycle: ex_valid=1, ex_pc=0x100, ex_rs1_data=0x11, stall_if_id stays 0.
- Load-use: enable_bubble=1 with id pc=0x104. Same cycle: stall_if_id=1. Next cycle: NOP in EX, stall_count=1. Following cycle: with enable_rs1_forward_from_wb=1 and wb_data=0xDEAD, ex_pc=0x104 and ex_rs1_data=0xDEAD.
- Flush over bubble: flush=1 and enable_bubble=1 in the same cycle. Response: stall_if_id=0, NOP in EX, FSM stays RUN, stall_count unchanged.
- Flush in BUBBLE: bubble at pc=0x200, then flush=1. Response: EX gets NOP, pc 0x200 is never issued, and the next decode bundle issues normally.
- x0 guard: id_rs2=0 with enable_rs2_forward_from_wb=1 and wb_data=0x55. Response: ex_rs2_data=0.
- Reset mid-bubble, then saturation:
  - Assert reset in BUBBLE: all outputs 0 next cycle, hold dropped.
  - Preload stall_count at 0xFFFF and issue one more bubble: stall_count stays 0xFFFF.
